// File: rtl/spi_cfg_sequencer.sv
// rtl/spi_cfg_sequencer.sv - boot-table replay and host arbitration for the SPI config write engine
// Enforces power-up delay, inter-frame gaps and an engine timeout; reports progress.
module spi_cfg_sequencer #(
  parameter int           NUM_INIT       = 5,
  parameter logic [191:0] INIT_TABLE     = {72'h0, 24'h001606, 24'h001804, 24'h002134,
                                            24'h001531, 24'h000d04},
  parameter int           POWERUP_CYCLES = 1000,
  parameter int           GAP_CYCLES     = 1000,
  parameter int           TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_req,
  input  logic [23:0] host_word,
  output logic        host_ack,
  output logic        eng_start,
  output logic [23:0] eng_word,
  input  logic        eng_busy,
  input  logic        eng_done,
  output logic        init_done,
  output logic        busy,
  output logic        err_timeout,
  output logic [7:0]  frame_count
);

  localparam logic [3:0]  N_INIT   = (NUM_INIT > 8) ? 4'd8 : 4'(NUM_INIT);
  localparam logic [31:0] PWR_LAST = 32'(POWERUP_CYCLES - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_ARB,
    S_ISSUE,
    S_WAIT,
    S_GAP
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] tcnt;
  logic [3:0]  index;
  logic        from_init;

  assign busy = (state != S_ARB);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_PWRUP;
      cnt         <= '0;
      tcnt        <= '0;
      index       <= '0;
      from_init   <= 1'b0;
      host_ack    <= 1'b0;
      eng_start   <= 1'b0;
      eng_word    <= '0;
      init_done   <= 1'b0;
      err_timeout <= 1'b0;
      frame_count <= '0;
    end else begin
      host_ack  <= 1'b0;
      eng_start <= 1'b0;
      case (state)
        S_PWRUP: begin
          if (cnt == PWR_LAST) begin
            cnt   <= '0;
            state <= S_ARB;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_ARB: begin
          // The boot table always has priority; host is only served once it is finished.
          if (!eng_busy) begin
            if (!init_done) begin
              if (index < N_INIT) begin
                eng_word  <= INIT_TABLE[index[2:0]*24 +: 24];
                from_init <= 1'b1;
                state     <= S_ISSUE;
              end else begin
                init_done <= 1'b1;
              end
            end else if (host_req) begin
              eng_word  <= host_word;
              host_ack  <= 1'b1;
              from_init <= 1'b0;
              state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          eng_start <= 1'b1;
          tcnt      <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // A timed-out boot entry is skipped, not retried; eng_done wins a tie.
          if (eng_done || (tcnt == TO_LAST)) begin
            if (!eng_done) begin
              err_timeout <= 1'b1;
            end
            frame_count <= frame_count + 8'd1;
            if (from_init) begin
              index <= index + 4'd1;
            end
            cnt   <= '0;
            state <= S_GAP;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= S_ARB;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= S_PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// tb/tb_spi_cfg_sequencer.sv - directed scoreboard bench for spi_cfg_sequencer
// Engine model acks frames after a fixed delay and can hang on a chosen frame.
module tb_spi_cfg_sequencer;
  localparam int P   = 20;
  localparam int G   = 10;
  localparam int T   = 64;
  localparam int ACK = 5;
  localparam logic [191:0] TABLE = {72'h0, 24'h001606, 24'h001804, 24'h002134,
                                    24'h001531, 24'h000d04};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_req = 1'b0;
  logic [23:0] host_word = '0;
  logic        host_ack, eng_start, init_done, busy, err_timeout;
  logic [23:0] eng_word;
  logic [7:0]  frame_count;
  logic        eng_busy, eng_done;

  always #5 clk = ~clk;

  spi_cfg_sequencer #(
    .NUM_INIT(5), .INIT_TABLE(TABLE), .POWERUP_CYCLES(P),
    .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst), .host_req(host_req), .host_word(host_word),
    .host_ack(host_ack), .eng_start(eng_start), .eng_word(eng_word),
    .eng_busy(eng_busy), .eng_done(eng_done), .init_done(init_done),
    .busy(busy), .err_timeout(err_timeout), .frame_count(frame_count)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Engine model
  logic m_busy = 1'b0, m_done = 1'b0, m_drop = 1'b0;
  int   m_cnt = 0, m_starts = 0, drop_at = -1;
  logic force_busy = 1'b0, stray_done = 1'b0;
  assign eng_busy = m_busy | force_busy;
  assign eng_done = m_done | stray_done;

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (eng_start) begin
      m_busy   <= 1'b1;
      m_cnt    <= 1;
      m_drop   <= (m_starts == drop_at);
      m_starts <= m_starts + 1;
    end else if (m_busy) begin
      if (m_cnt == ACK) begin
        m_busy <= 1'b0;
        m_done <= !m_drop;
      end
      m_cnt <= m_cnt + 1;
    end
  end

  // Scoreboard monitor
  logic [23:0] exp_q[$];
  int   starts = 0, last_start = 0, last_done = -1, min_d2s = 1 << 30;
  logic early_ack = 1'b0;

  always @(negedge clk) begin
    if (rst) last_done = -1;
    if (host_ack && !init_done) early_ack = 1'b1;
    if (m_done) last_done = cyc;
    if (eng_start) begin
      starts++;
      if (last_done >= 0 && (cyc - last_done) < min_d2s) min_d2s = cyc - last_done;
      last_start = cyc;
      check("sb_avail", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("sb_word", eng_word, exp_q.pop_front());
    end
  end

  // kind: 0 host_ack, 1 init_done, 2 err_timeout, 3 frame_count==arg, 4 !busy
  task automatic wait_until(input int kind, input int arg, input int lim, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      case (kind)
        0: seen = host_ack;
        1: seen = init_done;
        2: seen = err_timeout;
        3: seen = (frame_count == arg[7:0]);
        default: seen = !busy;
      endcase
      if (seen) break;
    end
  endtask

  task automatic check_reset_vals();
    check("rst_host_ack", host_ack, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_word", eng_word, 0);
    check("rst_init_done", init_done, 0);
    check("rst_busy", busy, 1);
    check("rst_err", err_timeout, 0);
    check("rst_frame_count", frame_count, 0);
  endtask

  task automatic push_table();
    logic [191:0] t;
    t = TABLE;
    for (int i = 0; i < 5; i++) exp_q.push_back(t[i*24 +: 24]);
  endtask

  task automatic release_and_check_latency(input string tag);
    rst = 1'b0;
    repeat (P + 1) @(negedge clk);
    check({tag, "_early"}, eng_start, 0);
    @(negedge clk);
    check({tag, "_start"}, eng_start, 1);
  endtask

  bit          seen;
  int          base;
  logic [23:0] w;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_reset_vals();

    // Boot replay with host request pending from reset
    exp_q.delete();
    push_table();
    exp_q.push_back(24'h00ab12);
    host_req  = 1'b1;
    host_word = 24'h00ab12;
    base      = starts;
    release_and_check_latency("boot_latency");
    wait_until(0, 0, 2000, seen);
    check("boot_host_ack_seen", seen, 1);
    check("boot_init_done_at_ack", init_done, 1);
    host_req = 1'b0;
    wait_until(3, 6, 500, seen);
    check("boot_fc6_seen", seen, 1);
    check("boot_frame_count", frame_count, 6);
    check("boot_no_early_ack", early_ack, 0);
    check("boot_err_clear", err_timeout, 0);
    check("boot_done_to_start", min_d2s, G + 3);
    check("boot_starts", starts - base, 6);
    check("boot_sb_drained", exp_q.size(), 0);

    // Timeout on boot entry 2
    rst = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    push_table();
    drop_at = m_starts + 2;
    rst = 1'b0;
    wait_until(2, 0, 2000, seen);
    check("to_err_seen", seen, 1);
    check("to_err_latency", cyc - last_start, T);
    wait_until(1, 0, 2000, seen);
    check("to_init_done", seen, 1);
    check("to_frame_count", frame_count, 5);
    check("to_sb_drained", exp_q.size(), 0);
    drop_at = -1;

    // Busy hold-off in ARB
    force_busy = 1'b1;
    w = 24'h00c3a5;
    exp_q.push_back(w);
    host_word = w;
    host_req  = 1'b1;
    base      = starts;
    seen      = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (host_ack) seen = 1'b1;
    end
    check("hold_no_ack", seen, 0);
    check("hold_no_start", starts - base, 0);
    force_busy = 1'b0;
    @(negedge clk);
    check("hold_ack_next", host_ack, 1);
    host_req = 1'b0;
    wait_until(3, 6, 500, seen);
    check("hold_fc6", seen, 1);
    check("hold_err_sticky", err_timeout, 1);

    // Stray eng_done in GAP and ARB
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    wait_until(4, 0, 500, seen);
    check("stray_arb_seen", seen, 1);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_frame_count", frame_count, 6);
    check("stray_no_start", starts - base, 1);

    // Reset during WAIT of entry 3
    rst = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    push_table();
    base = starts;
    rst  = 1'b0;
    for (int i = 0; i < 2000 && (starts - base) < 4; i++) @(negedge clk);
    check("mid_reached_entry3", starts - base, 4);
    repeat (2) @(negedge clk);
    check("mid_fc_before_rst", frame_count, 3);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals();
    exp_q.delete();
    push_table();
    release_and_check_latency("mid_latency");
    wait_until(1, 0, 2000, seen);
    check("mid_init_done", seen, 1);
    check("mid_frame_count", frame_count, 5);

    // frame_count wrap through host frames
    for (int i = 0; i < 251; i++) begin
      w = 24'($urandom);
      exp_q.push_back(w);
      host_word = w;
      host_req  = 1'b1;
      wait_until(0, 0, 300, seen);
      check("wrap_ack", seen, 1);
      host_req = 1'b0;
      if (i == 249) begin
        wait_until(3, 255, 300, seen);
        check("wrap_fc255", frame_count, 255);
      end
    end
    wait_until(3, 0, 300, seen);
    check("wrap_fc0", frame_count, 0);
    check("wrap_sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
